bitblade_column_ctrl: RTL and testbench



---
 rtl/bitblade_pkg.sv | 33 +++
 rtl/bitblade_prec_decode.sv | 35 +++
 rtl/bitblade_column_ctrl.sv | 135 +++++++++++++
 tb/tb_bitblade_column_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bitblade_pkg.sv
// Shared types and constants for the BitBlade column controller and its
// precision decoder.
package bitblade_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } fsm_state_t;

  // Weight MUX_REG control codes
  localparam logic [1:0] ST_HOLD = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_COMP = 2'b10;

  // Precision encodings; code 3 is an alias for 8-bit
  localparam logic [1:0] PREC_2B     = 2'd0;
  localparam logic [1:0] PREC_4B     = 2'd1;
  localparam logic [1:0] PREC_8B     = 2'd2;
  localparam logic [1:0] PREC_8B_ALT = 2'd3;

  // Number of 2-bit slices (PE rows/columns) one operand spans: 1, 2 or 4
  function automatic logic [2:0] group_span(input logic [1:0] bits);
    case (bits)
      PREC_2B: group_span = 3'd1;
      PREC_4B: group_span = 3'd2;
      default: group_span = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/bitblade_prec_decode.sv
// Combinational precision decode: per-PE shift nibbles and per-group sign
// flags for a 4x4 grid of 2-bit PEs.
module bitblade_prec_decode
  import bitblade_pkg::*;
(
  input  logic [1:0]  in_bits,
  input  logic [1:0]  w_bits,
  input  logic        in_signed,
  input  logic        w_signed,
  output logic [63:0] signal,
  output logic [3:0]  sign_x,
  output logic [3:0]  sign_y
);

  logic [2:0] x_mask;
  logic [2:0] y_mask;

  // Spans are powers of two, so "mod span" is a mask with span-1
  assign x_mask = group_span(in_bits) - 3'd1;
  assign y_mask = group_span(w_bits) - 3'd1;

  always_comb begin
    signal = '0;
    sign_x = '0;
    sign_y = '0;
    for (int k = 0; k < 16; k++) begin
      signal[4*k +: 4] = {(3'(k / 4) & x_mask) + (3'(k % 4) & y_mask), 1'b0};
    end
    for (int g = 0; g < 4; g++) begin
      sign_x[g] = in_signed & ((3'(g) & x_mask) == x_mask);
      sign_y[g] = w_signed & ((3'(g) & y_mask) == y_mask);
    end
  end

endmodule

// File: rtl/bitblade_column_ctrl.sv
// Sequencer for one BitBlade 16-PE column: latches and decodes the precision
// configuration, then walks the column through weight load, compute and drain.
module bitblade_column_ctrl
  import bitblade_pkg::*;
#(
  parameter int VEC_W     = 16,
  parameter int WLOAD_CYC = 2,
  parameter int PIPE_LAT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cfg_in_bits,
  input  logic [1:0]       cfg_w_bits,
  input  logic             cfg_in_signed,
  input  logic             cfg_w_signed,
  input  logic [VEC_W-1:0] cfg_num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state,
  output logic [63:0]      signal,
  output logic [3:0]       sign_x,
  output logic [3:0]       sign_y,
  output logic [1:0]       input_bitwidth,
  output logic             acc_clear,
  output logic             out_valid
);

  localparam logic [VEC_W-1:0] ONE        = VEC_W'(1);
  localparam logic [VEC_W-1:0] LOAD_LAST  = VEC_W'(WLOAD_CYC - 1);
  localparam logic [VEC_W-1:0] DRAIN_LAST = VEC_W'(PIPE_LAT - 1);

  fsm_state_t       cur_st, nxt_st;
  logic [VEC_W-1:0] cnt, cnt_nxt;
  logic [VEC_W-1:0] num_vec;
  logic             start_acc;
  logic [63:0]      dec_signal;
  logic [3:0]       dec_sign_x, dec_sign_y;

  bitblade_prec_decode u_dec (
    .in_bits   (cfg_in_bits),
    .w_bits    (cfg_w_bits),
    .in_signed (cfg_in_signed),
    .w_signed  (cfg_w_signed),
    .signal    (dec_signal),
    .sign_x    (dec_sign_x),
    .sign_y    (dec_sign_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_st         <= S_IDLE;
      cnt            <= '0;
      num_vec        <= '0;
      signal         <= '0;
      sign_x         <= '0;
      sign_y         <= '0;
      input_bitwidth <= '0;
    end else begin
      cur_st <= nxt_st;
      cnt    <= cnt_nxt;
      if (start_acc) begin
        num_vec        <= cfg_num_vec;
        signal         <= dec_signal;
        sign_x         <= dec_sign_x;
        sign_y         <= dec_sign_y;
        input_bitwidth <= (cfg_in_bits == PREC_8B_ALT) ? PREC_8B : cfg_in_bits;
      end
    end
  end

  // Input handshake: a vector transfers in any cycle where in_valid and
  // in_ready are both high; in_ready depends only on the FSM state, never on
  // in_valid, and the buffer may hold in_valid low for any number of cycles.
  always_comb begin
    nxt_st    = cur_st;
    cnt_nxt   = cnt;
    start_acc = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    state     = ST_HOLD;
    acc_clear = 1'b0;
    out_valid = 1'b0;
    case (cur_st)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          cnt_nxt   = '0;
          nxt_st    = S_LOAD;
        end
      end
      S_LOAD: begin
        state     = ST_LOAD;
        acc_clear = (cnt == '0);
        if (cnt == LOAD_LAST) begin
          cnt_nxt = '0;
          nxt_st  = (num_vec == '0) ? S_DONE : S_COMPUTE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      S_COMPUTE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state = ST_COMP;
          if (cnt + ONE == num_vec) begin
            cnt_nxt = '0;
            nxt_st  = S_DRAIN;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          out_valid = 1'b1;
          cnt_nxt   = '0;
          nxt_st    = S_DONE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        nxt_st = S_IDLE;
      end
      default: nxt_st = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bitblade_column_ctrl.sv
// Directed bench for bitblade_column_ctrl: expected timing events are queued
// per job and a negedge monitor pops and compares them as the DUT emits them.
module tb_bitblade_column_ctrl;

  localparam int VEC_W   = 16;
  localparam int W       = 13;
  localparam int JOB_CYC = 16;

  localparam logic [2:0] K_CLR   = 3'd0;
  localparam logic [2:0] K_LOAD  = 3'd1;
  localparam logic [2:0] K_HS    = 3'd2;
  localparam logic [2:0] K_STALL = 3'd3;
  localparam logic [2:0] K_OV    = 3'd4;
  localparam logic [2:0] K_DONE  = 3'd5;
  localparam logic [2:0] K_BLO   = 3'd6;
  localparam logic [2:0] K_STRAY = 3'd7;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       cfg_in_bits = '0;
  logic [1:0]       cfg_w_bits = '0;
  logic             cfg_in_signed = 1'b0;
  logic             cfg_w_signed = 1'b0;
  logic [VEC_W-1:0] cfg_num_vec = '0;
  logic             in_valid = 1'b0;
  logic             in_ready, busy, done, acc_clear, out_valid;
  logic [1:0]       state, input_bitwidth;
  logic [63:0]      signal;
  logic [3:0]       sign_x, sign_y;

  int cyc = 0;
  int t0 = 0;
  int mon_rel;
  int checks = 0;
  int failures = 0;
  logic prev_busy = 1'b0;
  logic [W-1:0] exp_q[$];

  bitblade_column_ctrl #(.VEC_W(VEC_W), .WLOAD_CYC(2), .PIPE_LAT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_in_bits    (cfg_in_bits),
    .cfg_w_bits     (cfg_w_bits),
    .cfg_in_signed  (cfg_in_signed),
    .cfg_w_signed   (cfg_w_signed),
    .cfg_num_vec    (cfg_num_vec),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .busy           (busy),
    .done           (done),
    .state          (state),
    .signal         (signal),
    .sign_x         (sign_x),
    .sign_y         (sign_y),
    .input_bitwidth (input_bitwidth),
    .acc_clear      (acc_clear),
    .out_valid      (out_valid)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [1:0] st, input int rel);
    exp_q.push_back({k, st, 8'(rel)});
  endtask

  // Scoreboard pop/compare for one observed event
  task automatic see(input logic [2:0] k, input int rel);
    logic [W-1:0] got;
    logic [W-1:0] want;
    got = {k, state, 8'(rel)};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d state=%b cycle=%0d, required none",
               got[12:10], got[9:8], got[7:0]);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        failures++;
        $display("FAIL event: got kind=%0d state=%b cycle=%0d, required kind=%0d state=%b cycle=%0d",
                 got[12:10], got[9:8], got[7:0], want[12:10], want[9:8], want[7:0]);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    mon_rel = cyc - t0;
    if (acc_clear) see(K_CLR, mon_rel);
    if (state == 2'b01) see(K_LOAD, mon_rel);
    if (in_ready && in_valid) see(K_HS, mon_rel);
    if (in_ready && !in_valid) see(K_STALL, mon_rel);
    if (state == 2'b11 || (state == 2'b10 && !(in_ready && in_valid))) see(K_STRAY, mon_rel);
    if (out_valid) see(K_OV, mon_rel);
    if (done) see(K_DONE, mon_rel);
    if (prev_busy && !busy) see(K_BLO, mon_rel);
    prev_busy = busy;
  end

  // Cycle r of a job is the period after the r-th edge following start
  task automatic run_job(input logic [1:0] ib, input logic [1:0] wb,
                         input logic is, input logic ws, input int nv,
                         input int stall_r, input int rst_r, input int xstart_r,
                         input logic [63:0] e_sig, input logic [3:0] e_sx,
                         input logic [3:0] e_sy, input logic [1:0] e_ibw);
    @(posedge clk); #1;
    cfg_in_bits = ib; cfg_w_bits = wb; cfg_in_signed = is; cfg_w_signed = ws;
    cfg_num_vec = VEC_W'(nv);
    start = 1'b1;
    in_valid = 1'b1;
    t0 = cyc;
    for (int r = 1; r <= JOB_CYC; r++) begin
      @(posedge clk); #1;
      start = (r == xstart_r);
      if (r == xstart_r) begin
        cfg_in_bits = 2'd0; cfg_w_bits = 2'd0;
        cfg_in_signed = 1'b0; cfg_w_signed = 1'b0;
        cfg_num_vec = VEC_W'(5);
      end
      in_valid = (r != stall_r);
      reset = (r == rst_r);
      if (r == 1) begin
        chk("busy_after_start", busy, 1'b1);
        chk("signal", signal, e_sig);
        chk("sign_x_y", {sign_x, sign_y}, {e_sx, e_sy});
        chk("input_bitwidth", input_bitwidth, e_ibw);
      end
      if (rst_r > 0 && r == rst_r + 1)
        chk("outputs_after_reset",
            {in_ready, busy, done, state, signal, sign_x, sign_y, input_bitwidth, acc_clear, out_valid},
            '0);
    end
    in_valid = 1'b0;
    if (rst_r == 0) chk("config_held_idle", {signal, sign_x, sign_y}, {e_sig, e_sx, e_sy});
    chk("events_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic push_std_job();
    push(K_CLR, 2'b01, 1); push(K_LOAD, 2'b01, 1); push(K_LOAD, 2'b01, 2);
    push(K_HS, 2'b10, 3); push(K_HS, 2'b10, 4); push(K_HS, 2'b10, 5);
    push(K_OV, 2'b00, 9); push(K_DONE, 2'b00, 10); push(K_BLO, 2'b00, 11);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {in_ready, busy, done, state, signal, sign_x, sign_y, input_bitwidth, acc_clear, out_valid},
        '0);
    reset = 1'b0;

    // 8b x 8b signed, 3 vectors, no stall
    push_std_job();
    run_job(2'd2, 2'd2, 1'b1, 1'b1, 3, 0, 0, 0,
            64'hCA86_A864_8642_6420, 4'b1000, 4'b1000, 2'd2);

    // 4b x 4b signed, 3 vectors, stall in cycle 4
    push(K_CLR, 2'b01, 1); push(K_LOAD, 2'b01, 1); push(K_LOAD, 2'b01, 2);
    push(K_HS, 2'b10, 3); push(K_STALL, 2'b00, 4); push(K_HS, 2'b10, 5);
    push(K_HS, 2'b10, 6); push(K_OV, 2'b00, 10); push(K_DONE, 2'b00, 11);
    push(K_BLO, 2'b00, 12);
    run_job(2'd1, 2'd1, 1'b1, 1'b1, 3, 4, 0, 0,
            64'h4242_2020_4242_2020, 4'b1010, 4'b1010, 2'd1);

    // 8b (alias code 3) x 2b unsigned, zero vectors
    push(K_CLR, 2'b01, 1); push(K_LOAD, 2'b01, 1); push(K_LOAD, 2'b01, 2);
    push(K_DONE, 2'b00, 3); push(K_BLO, 2'b00, 4);
    run_job(2'd3, 2'd0, 1'b0, 1'b0, 0, 0, 0, 0,
            64'h6666_4444_2222_0000, 4'b0000, 4'b0000, 2'd2);

    // Reset during the second compute cycle: no done, no out_valid
    push(K_CLR, 2'b01, 1); push(K_LOAD, 2'b01, 1); push(K_LOAD, 2'b01, 2);
    push(K_HS, 2'b10, 3); push(K_HS, 2'b10, 4); push(K_BLO, 2'b00, 5);
    run_job(2'd2, 2'd2, 1'b1, 1'b1, 3, 0, 4, 0,
            64'hCA86_A864_8642_6420, 4'b1000, 4'b1000, 2'd2);

    // start with a different config while busy must be ignored
    push_std_job();
    run_job(2'd1, 2'd1, 1'b1, 1'b1, 3, 0, 0, 3,
            64'h4242_2020_4242_2020, 4'b1010, 4'b1010, 2'd1);

    // start coincident with reset must be ignored
    @(posedge clk); #1;
    cfg_in_bits = 2'd2; cfg_w_bits = 2'd2; cfg_in_signed = 1'b1; cfg_w_signed = 1'b1;
    cfg_num_vec = VEC_W'(3);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("start_with_reset_ignored", {busy, state, in_ready, signal}, '0);
    repeat (4) @(posedge clk);
    #1;
    chk("no_events_after_reset_start", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
